// File: rtl/demux1to4_if.sv
// Handshake bundle between one producer, the 1-to-4 distributor and its four consumers.
// master: the producer/consumer side driving the block; slave: the demux1to4 block itself.
interface demux1to4_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] i_data;
    logic [1:0]            i_sel;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid0;
    logic                  o_valid1;
    logic                  o_valid2;
    logic                  o_valid3;
    logic                  i_ready0;
    logic                  i_ready1;
    logic                  i_ready2;
    logic                  i_ready3;

    modport master (
        output i_data, i_sel, i_valid,
        output i_ready0, i_ready1, i_ready2, i_ready3,
        input  o_ready, o_data,
        input  o_valid0, o_valid1, o_valid2, o_valid3
    );

    modport slave (
        input  i_data, i_sel, i_valid,
        input  i_ready0, i_ready1, i_ready2, i_ready3,
        output o_ready, o_data,
        output o_valid0, o_valid1, o_valid2, o_valid3
    );
endinterface

// File: rtl/demux1to4.sv
// Registered 1-to-4 distributor with valid/ready handshake and in-order delivery.
// Define DEMUX1TO4_SKID_EN to add a one-entry skid buffer and a registered o_ready.
module demux1to4 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic         i_clock,
    input logic         i_reset,
    demux1to4_if.slave  bus
);

    localparam int unsigned SEL_WIDTH = 2;

    logic                  r_valid;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [DATA_WIDTH-1:0] r_data;

    logic [3:0] ready_vec;
    logic       sel_ready;
    logic       out_xfer;
    logic       in_xfer;

    // Only the ready of the currently addressed destination matters.
    assign ready_vec = {bus.i_ready3, bus.i_ready2, bus.i_ready1, bus.i_ready0};
    assign sel_ready = ready_vec[r_sel];
    assign out_xfer  = r_valid & sel_ready;
    assign in_xfer   = bus.i_valid & bus.o_ready;

    assign bus.o_data   = r_data;
    assign bus.o_valid0 = r_valid & (r_sel == SEL_WIDTH'(0));
    assign bus.o_valid1 = r_valid & (r_sel == SEL_WIDTH'(1));
    assign bus.o_valid2 = r_valid & (r_sel == SEL_WIDTH'(2));
    assign bus.o_valid3 = r_valid & (r_sel == SEL_WIDTH'(3));

`ifdef DEMUX1TO4_SKID_EN
    logic                  s_valid;
    logic [SEL_WIDTH-1:0]  s_sel;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  r_ready;
    logic                  s_valid_next;

    assign bus.o_ready = r_ready;

    // Skid holds a word only when it arrives while the main register is stalled.
    assign s_valid_next = s_valid ? ~out_xfer : (in_xfer & r_valid & ~out_xfer);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_data  <= '0;
            s_valid <= 1'b0;
            s_sel   <= '0;
            s_data  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= ~s_valid_next;
            if (s_valid) begin
                if (out_xfer) begin
                    r_sel   <= s_sel;
                    r_data  <= s_data;
                    s_valid <= 1'b0;
                end
            end else if (in_xfer) begin
                if (!r_valid || out_xfer) begin
                    r_valid <= 1'b1;
                    r_sel   <= bus.i_sel;
                    r_data  <= bus.i_data;
                end else begin
                    s_valid <= 1'b1;
                    s_sel   <= bus.i_sel;
                    s_data  <= bus.i_data;
                end
            end else if (out_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end
`else
    // Reset forces ready high; the flops ignore the input while reset is asserted.
    assign bus.o_ready = i_reset | ~r_valid | sel_ready;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_data  <= '0;
        end else if (in_xfer) begin
            r_valid <= 1'b1;
            r_sel   <= bus.i_sel;
            r_data  <= bus.i_data;
        end else if (out_xfer) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_demux1to4.sv
// Scoreboard bench for demux1to4: words pushed on input transfer, popped on output transfer.
module tb_demux1to4;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] data;
    } exp_t;

`ifdef DEMUX1TO4_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    demux1to4_if #(.DATA_WIDTH(16)) bus ();

    demux1to4 #(.DATA_WIDTH(16)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    wire [3:0] vv  = {bus.o_valid3, bus.o_valid2, bus.o_valid1, bus.o_valid0};
    wire [3:0] rdy = {bus.i_ready3, bus.i_ready2, bus.i_ready1, bus.i_ready0};

    function automatic logic [1:0] oh2idx(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Scoreboard monitor: sampled mid-cycle, transfers take effect at the next rising edge.
    always @(negedge clk) begin
        exp_t f;
        if (rst) begin
            q.delete();
        end else begin
            if (vv != 4'b0000) begin
                checks++;
                if (!$onehot(vv)) begin
                    errors++;
                    $display("FAIL onehot valids=%b required one-hot", vv);
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious valids=%b data=%h required no word", vv, bus.o_data);
                end else begin
                    f = q[0];
                    if (oh2idx(vv) !== f.sel || bus.o_data !== f.data) begin
                        errors++;
                        $display("FAIL order got sel=%0d data=%h required sel=%0d data=%h",
                                 oh2idx(vv), bus.o_data, f.sel, f.data);
                    end
                    if ((vv & rdy) != 4'b0000) void'(q.pop_front());
                end
            end
            if (bus.i_valid && bus.o_ready) q.push_back({bus.i_sel, bus.i_data});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_readies(input logic [3:0] r);
        {bus.i_ready3, bus.i_ready2, bus.i_ready1, bus.i_ready0} = r;
    endtask

    // Offer a word and return at accept edge + 1.
    task automatic send(input logic [15:0] d, input logic [1:0] s, output bit ok);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_sel   = s;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = bus.o_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout data=%h accepted=0 required 1", d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'hDEAD;
        bus.i_sel   = 2'd1;
        set_readies(4'hF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (vv !== 4'b0000 || bus.o_data !== 16'h0000 || bus.o_ready !== !SKID) begin
                errors++;
                $display("FAIL reset_state valids=%b data=%h ready=%b required 0000/0000/%b",
                         vv, bus.o_data, bus.o_ready, !SKID);
            end
        end
        rst = 1'b0;
        bus.i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (vv !== 4'b0000) begin
                errors++;
                $display("FAIL reset_release valids=%b required 0000", vv);
            end
        end
    endtask

    task automatic test_routing();
        logic [15:0] wd[4];
        bit ok;
        wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        set_readies(4'hF);
        for (int k = 0; k < 4; k++) begin
            send(wd[k], 2'(k), ok);
            checks++;
            if (vv !== (4'(1) << k) || bus.o_data !== wd[k]) begin
                errors++;
                $display("FAIL routing valids=%b data=%h required %b/%h",
                         vv, bus.o_data, 4'(1) << k, wd[k]);
            end
        end
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        bit ok;
        int acc = 0;
        set_readies(4'b1011);
        send(16'hA5A5, 2'd2, ok);
        bus.i_data  = 16'hB0B0;
        bus.i_sel   = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (vv !== 4'b0100 || bus.o_data !== 16'hA5A5) begin
                errors++;
                $display("FAIL stall_hold valids=%b data=%h required 0100/a5a5", vv, bus.o_data);
            end
            checks++;
            if (bus.o_ready !== (SKID && acc == 0)) begin
                errors++;
                $display("FAIL stall_ready ready=%b required %b", bus.o_ready, SKID && acc == 0);
            end
            if (bus.i_valid && bus.o_ready) acc++;
            @(posedge clk);
            #1;
            if (acc > 0) bus.i_valid = 1'b0;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (acc != (SKID ? 1 : 0)) begin
            errors++;
            $display("FAIL stall_accepts got=%0d required %0d", acc, SKID ? 1 : 0);
        end
        set_readies(4'hF);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_hol();
        bit ok;
        bit acc = 1'b0;
        bit seen = 1'b0;
        set_readies(4'b1110);
        send(16'h0001, 2'd0, ok);
        bus.i_data = 16'h0002;
        bus.i_sel  = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (vv !== 4'b0001 || bus.o_data !== 16'h0001) begin
                errors++;
                $display("FAIL hol_block valids=%b data=%h required 0001/0001", vv, bus.o_data);
            end
            if (bus.i_valid && bus.o_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            if (acc) bus.i_valid = 1'b0;
        end
        set_readies(4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.i_valid && bus.o_ready) acc = 1'b1;
            if (vv == 4'b1000 && bus.o_data == 16'h0002) seen = 1'b1;
            @(posedge clk);
            #1;
            if (acc) bus.i_valid = 1'b0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hol_release seen=0 required 1");
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_readies(4'b1101);
        send(16'h7777, 2'd1, ok);
        if (SKID) send(16'h8888, 2'd2, ok);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        if (!SKID) begin
            checks++;
            if (bus.o_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_ready ready=%b required 1", bus.o_ready);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (vv !== 4'b0000 || bus.o_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid valids=%b data=%h required 0000/0000", vv, bus.o_data);
        end
        set_readies(4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (vv !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_flush valids=%b required 0000", vv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_soak();
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            bus.i_valid = 1'($urandom_range(0, 1));
            bus.i_sel   = 2'($urandom_range(0, 3));
            bus.i_data  = 16'($urandom);
            set_readies({$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        set_readies(4'hF);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL soak_drain pending=%0d required 0", q.size());
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_sel   = '0;
        set_readies(4'hF);
        test_reset();
        test_routing();
        test_stall();
        test_hol();
        test_reset_mid();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1to4.md
# demux1to4

Registered 1-to-4 distributor with valid/ready handshake. Accepts one word per cycle from a single producer and delivers it to one of four consumers chosen by `i_sel`. It is the distributing counterpart of the 4-to-1 selector used on the datapath. It sits between one pipeline stage and four downstream units, such as writeback ports or functional-unit queues, and provides one pipeline register plus an optional skid entry.

## Interface

- `DATA_WIDTH`, default 16: width of the data bus.
- `i_clock`  in  1  — single clock; all logic on the rising edge.
- `i_reset`  in  1  — reset, synchronous, active-high.
- `i_data`  in  DATA_WIDTH  — input word.
- `i_sel`  in  2  — destination index, 0..3; sampled together with `i_data`.
- `i_valid`  in  1  — the producer offers `i_data`/`i_sel`.
- `o_ready`  out  1  — the block accepts a word this cycle.
- `o_data`  out  DATA_WIDTH  — registered word, shared by all four destinations.
- `o_valid0`..`o_valid3`  out  1 each  — the word on `o_data` is for destination N.
- `i_ready0`..`i_ready3`  in  1 each  — destination N consumes the word this cycle.

## Operation

- Input transfer: `i_valid & o_ready` on a rising edge. Output transfer on N: `o_validN & i_readyN`.
- Main register: `r_valid`, `r_sel`, `r_data`.
  - `o_data = r_data`.
  - `o_validN = r_valid & (r_sel == N)`.
  - At most one `o_validN` is high in any cycle.
- `i_readyM` for M ≠ `r_sel` is ignored and has no effect.
- Once `o_validN` is asserted, it and `o_data` stay stable until destination N consumes the word. Destinations do not see a word change under them.
- Words are delivered strictly in acceptance order, across all destinations. A word for destination 2 waits behind a stalled word for destination 0 (head-of-line blocking is intended).
- Simultaneous input and output transfer in the same cycle: the new word replaces the consumed one. No bubble is inserted.
- `i_sel` and `i_data` are don't-care while `i_valid` = 0.
- Reset while `i_reset` is high:
  - `r_valid` = 0, `r_sel` = 0, `r_data` = 0, so every `o_validN` = 0 and `o_data` = 0.
  - Any word in flight is discarded without being delivered.
  - With the skid configured: the skid entry is cleared and `o_ready` = 0 during reset.
  - Without the skid: `o_ready` = 1 during reset. Input transfers made while reset is high are ignored.
- The block never drops or duplicates an accepted word outside of reset.

## Timing

- Latency: a word accepted at edge k is visible on `o_data`/`o_validN` from edge k, i.e. in the following cycle. Minimum latency is 1 cycle.
- Throughput: 1 word per cycle while the addressed destination keeps its ready high.
- Without skid, `o_ready = ~r_valid | i_ready[r_sel]`. This is a combinational path from `i_readyN` to `o_ready`.
- With skid, `o_ready` is a flop output, so there is no combinational input-to-output path.
- Empty state: after reset, or when the last word is consumed with no new input.
  - The first word accepted appears on the outputs at the next edge.
- Full state: `r_valid` = 1 and the destination is not ready.
  - Without skid: `o_ready` = 0 in the same cycle.
  - With skid: `o_ready` stays 1 for one more word, which is parked in the skid entry. `o_ready` drops at the next edge.
- Skid drain: when the main register is consumed, the skid word moves to the main register at that edge. `o_ready` returns to 1 at the same edge.

## Configuration

- `DEMUX1TO4_SKID_EN` defined:
  - Adds a one-entry skid buffer (`s_valid`, `s_sel`, `s_data`).
  - `o_ready` is registered as `~s_valid`. Capacity is 2 words.
  - Full throughput is preserved with no combinational ready path.
- `DEMUX1TO4_SKID_EN` undefined:
  - No skid storage. Capacity is 1 word.
  - `o_ready` is combinational as given above.
- Both variants produce identical output sequences. Only `o_ready` timing and capacity differ.

## Test plan

- Reset state: hold `i_reset` high for 3 cycles with `i_valid` = 1.
  - Required: `o_valid0..3` = 0 and `o_data` = 0 throughout.
  - Required: no word is delivered after reset is released.
- Routing: with all readies high, send `0x1111`/sel0, `0x2222`/sel1, `0x3333`/sel2, `0x4444`/sel3 on back-to-back cycles.
  - Required: each word appears one cycle later on the matching `o_validN` only, one per cycle, in order.
- Stall: send `0xA5A5`/sel2 with `i_ready2` = 0 for 5 cycles while the other readies are high.
  - Required: `o_valid2` and `o_data` = `0xA5A5` stay stable for the whole stall.
  - Required: without skid, `o_ready` = 0 throughout the stall.
  - Required: with skid, exactly one more word is accepted during the stall, then `o_ready` = 0.
- Head-of-line ordering: send `0x0001`/sel0 with `i_ready0` = 0, then `0x0002`/sel3 with `i_ready3` = 1.
  - Required: `0x0002` is not presented until `0x0001` is consumed.
- Reset mid-operation: with a word stalled (and with skid, the skid entry full), pulse `i_reset` for 1 cycle.
  - Required: all valids are 0 on the next cycle and neither word is ever delivered.
- Random soak: run 10,000 cycles of random `i_valid`, `i_sel`, `i_data` and readies.
  - Required: the scoreboard confirms in-order, lossless, duplicate-free delivery to the correct destination.
